// File: rtl/sc_debounce_pkg.sv
// ---------------------------------------------------------------------------
// sc_debounce_pkg : state encoding and defaults for the push-button debouncer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sc_debounce_pkg;

  localparam logic [1:0] STATE_STABLE_HIGH = 2'd0;
  localparam logic [1:0] STATE_WAIT_LOW    = 2'd1;
  localparam logic [1:0] STATE_STABLE_LOW  = 2'd2;
  localparam logic [1:0] STATE_WAIT_HIGH   = 2'd3;

  localparam int unsigned DEBOUNCE_COUNT_MAX_DEFAULT   = 500000;
  localparam int unsigned DEBOUNCE_COUNT_WIDTH_DEFAULT = 19;

  typedef enum logic [1:0] {
    ST_STABLE_HIGH = STATE_STABLE_HIGH,
    ST_WAIT_LOW    = STATE_WAIT_LOW,
    ST_STABLE_LOW  = STATE_STABLE_LOW,
    ST_WAIT_HIGH   = STATE_WAIT_HIGH
  } debounce_state_e;

  // The output is held low throughout the whole "pressed" half of the FSM.
  function automatic logic is_low_state(input debounce_state_e state);
    return (state == ST_STABLE_LOW) || (state == ST_WAIT_HIGH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sc_debounce_channel.sv
// ---------------------------------------------------------------------------
// sc_debounce_channel : 2-FF synchroniser, debounce FSM and output FF, one bit
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sc_debounce_channel
  import sc_debounce_pkg::*;
#(
  parameter int unsigned COUNT_MAX   = DEBOUNCE_COUNT_MAX_DEFAULT,
  parameter int unsigned COUNT_WIDTH = DEBOUNCE_COUNT_WIDTH_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_n_i,
  output logic button_n_o
);

  localparam logic [COUNT_WIDTH-1:0] CNT_LAST = COUNT_WIDTH'(COUNT_MAX - 1);

  logic                   sync1_q;
  logic                   sync2_q;
  debounce_state_e        state_q;
  debounce_state_e        state_d;
  logic [COUNT_WIDTH-1:0] cnt_q;
  logic [COUNT_WIDTH-1:0] cnt_d;
  logic                   out_q;
  logic                   out_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_STABLE_HIGH: begin
        cnt_d = '0;
        if (!sync2_q) state_d = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (sync2_q) begin
          state_d = ST_STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      ST_STABLE_LOW: begin
        cnt_d = '0;
        if (sync2_q) state_d = ST_WAIT_HIGH;
      end
      ST_WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = ST_STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_STABLE_HIGH;
        cnt_d   = '0;
      end
    endcase
    // Output follows the next state so it changes on the same edge as STABLE_* entry.
    out_d = !is_low_state(state_d);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= ST_STABLE_HIGH;
      cnt_q   <= '0;
      out_q   <= 1'b1;
    end else begin
      sync1_q <= button_n_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign button_n_o = out_q;

endmodule

`default_nettype wire

// File: rtl/sc_debounce_pushbutton.sv
// ---------------------------------------------------------------------------
// sc_debounce_pushbutton : independent debouncers for active-low push buttons
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sc_debounce_pushbutton
  import sc_debounce_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS = 2,
  parameter int unsigned COUNT_MAX   = DEBOUNCE_COUNT_MAX_DEFAULT,
  parameter int unsigned COUNT_WIDTH = DEBOUNCE_COUNT_WIDTH_DEFAULT
) (
  input  logic                   SC_DEBOUNCE_CLOCK_50,
  input  logic                   SC_DEBOUNCE_RESET_InHigh,
  input  logic [NUM_BUTTONS-1:0] SC_DEBOUNCE_button_InLow,
  output logic [NUM_BUTTONS-1:0] SC_DEBOUNCE_button_OutLow
);

  for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_channel
    sc_debounce_channel #(
      .COUNT_MAX   (COUNT_MAX),
      .COUNT_WIDTH (COUNT_WIDTH)
    ) u_channel (
      .clk_i      (SC_DEBOUNCE_CLOCK_50),
      .rst_i      (SC_DEBOUNCE_RESET_InHigh),
      .button_n_i (SC_DEBOUNCE_button_InLow[gi]),
      .button_n_o (SC_DEBOUNCE_button_OutLow[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_sc_debounce_pushbutton.sv
// ---------------------------------------------------------------------------
// tb_sc_debounce_pushbutton : scenario tasks plus a sample-window reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sc_debounce_pushbutton;

  localparam int NB = 2;
  localparam int CM = 4;
  localparam int CW = 3;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic [NB-1:0] btn_n = '1;
  logic [NB-1:0] out_n;

  int errors = 0;
  int checks = 0;
  logic [NB-1:0] exp;

  always #10 clk = ~clk;

  sc_debounce_pushbutton #(
    .NUM_BUTTONS (NB),
    .COUNT_MAX   (CM),
    .COUNT_WIDTH (CW)
  ) dut (
    .SC_DEBOUNCE_CLOCK_50      (clk),
    .SC_DEBOUNCE_RESET_InHigh  (rst),
    .SC_DEBOUNCE_button_InLow  (btn_n),
    .SC_DEBOUNCE_button_OutLow (out_n)
  );

  // Reference: a bit flips once its last CM+1 synchronised samples all disagree with it.
  logic [NB-1:0] m_s1  = '1;
  logic [NB-1:0] m_s2  = '1;
  logic [NB-1:0] m_out = '1;
  logic [CM:0]   m_hist [NB];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_s1  = '1;
      m_s2  = '1;
      m_out = '1;
      for (int i = 0; i < NB; i++) m_hist[i] = '1;
    end else begin
      for (int i = 0; i < NB; i++) begin
        m_hist[i] = {m_hist[i][CM-1:0], m_s2[i]};
        if (m_hist[i] == {(CM+1){~m_out[i]}}) m_out[i] = ~m_out[i];
      end
      m_s2 = m_s1;
      m_s1 = btn_n;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    btn_n = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (out_n !== 2'b11) begin
        errors++;
        $display("FAIL reset_hold: cycle %0d got %b expected 11", i, out_n);
      end
    end
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp = (i < 7) ? 2'b11 : 2'b00;
      checks++;
      if (out_n !== exp) begin
        errors++;
        $display("FAIL reset_release_latency: step %0d got %b expected %b", i, out_n, exp);
      end
    end
    btn_n = 2'b11;
    idle(8);
    checks++;
    if (out_n !== 2'b11) begin
      errors++;
      $display("FAIL reset_release_back_high: got %b expected 11", out_n);
    end
  endtask

  task automatic test_clean_press();
    btn_n = 2'b10;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp = {1'b1, (i < 7) ? 1'b1 : 1'b0};
      checks++;
      if (out_n !== exp) begin
        errors++;
        $display("FAIL clean_press: step %0d got %b expected %b", i, out_n, exp);
      end
    end
    btn_n = 2'b11;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = {1'b1, (i < 7) ? 1'b0 : 1'b1};
      checks++;
      if (out_n !== exp) begin
        errors++;
        $display("FAIL clean_release: step %0d got %b expected %b", i, out_n, exp);
      end
    end
  endtask

  task automatic test_bounce();
    for (int e = 0; e < 4; e++) begin
      btn_n = {e[0], 1'b1};
      repeat (2) begin
        @(negedge clk);
        checks++;
        if (out_n !== 2'b11) begin
          errors++;
          $display("FAIL bounce_quiet: element %0d got %b expected 11", e, out_n);
        end
      end
    end
    btn_n = 2'b01;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = {(i < 7) ? 1'b1 : 1'b0, 1'b1};
      checks++;
      if (out_n !== exp) begin
        errors++;
        $display("FAIL bounce_settle: step %0d got %b expected %b", i, out_n, exp);
      end
    end
    btn_n = 2'b11;
    idle(8);
  endtask

  task automatic test_glitch();
    btn_n = 2'b10;
    idle(3);
    btn_n = 2'b11;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (out_n !== 2'b11) begin
        errors++;
        $display("FAIL glitch_rejected: step %0d got %b expected 11", i, out_n);
      end
    end
    // A clean press afterwards must see the full latency, proving the count restarted.
    btn_n = 2'b10;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      exp = {1'b1, (i < 7) ? 1'b1 : 1'b0};
      checks++;
      if (out_n !== exp) begin
        errors++;
        $display("FAIL glitch_then_press: step %0d got %b expected %b", i, out_n, exp);
      end
    end
    btn_n = 2'b11;
    idle(10);
  endtask

  task automatic test_reset_mid_count();
    btn_n = 2'b10;
    idle(3);
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_n !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_count: got %b expected 11", out_n);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      exp = {1'b1, (i < 7) ? 1'b1 : 1'b0};
      checks++;
      if (out_n !== exp) begin
        errors++;
        $display("FAIL reset_mid_relatch: step %0d got %b expected %b", i, out_n, exp);
      end
    end
    // Output is low now; an async reset must release it without waiting for a clock.
    #3 rst = 1'b1;
    #1;
    checks++;
    if (out_n !== 2'b11) begin
      errors++;
      $display("FAIL reset_async_release: got %b expected 11", out_n);
    end
    btn_n = 2'b11;
    @(negedge clk);
    rst = 1'b0;
    idle(8);
  endtask

  task automatic test_simultaneous();
    btn_n = 2'b00;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = (i < 7) ? 2'b11 : 2'b00;
      checks++;
      if (out_n !== exp) begin
        errors++;
        $display("FAIL simultaneous_press: step %0d got %b expected %b", i, out_n, exp);
      end
    end
    btn_n = 2'b10;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = {(i < 7) ? 1'b0 : 1'b1, 1'b0};
      checks++;
      if (out_n !== exp) begin
        errors++;
        $display("FAIL simultaneous_release1: step %0d got %b expected %b", i, out_n, exp);
      end
    end
    btn_n = 2'b11;
    idle(10);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (out_n !== m_out) begin
        errors++;
        $display("FAIL random_vs_model: cycle %0d got %b expected %b", c, out_n, m_out);
      end
      for (int b = 0; b < NB; b++)
        if ($urandom_range(5) == 0) btn_n[b] = ~btn_n[b];
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_reset_mid_count();
    test_simultaneous();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
